// File: rtl/mgmt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mgmt_arbiter_pkg
// Description : Shared definitions for the management-bus arbiter: bus field
//               widths, default response timeout and FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mgmt_arbiter_pkg;

    localparam int ADDR_W  = 32;   // management bus address width
    localparam int DATA_W  = 32;   // read / write data width
    localparam int WEN_W   = 2;    // halfword write enables
    localparam int DEF_TMO = 15;   // default cycles to wait for dn_ack

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mgmt_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mgmt_arbiter_rr_pick
// Description : Combinational N-way round-robin selector. Searches the
//               request vector upward starting one past the last grant,
//               wrapping at N, and returns the first set index.
// Ports       : req   [N-1:0] in  - request vector
//               last  [W-1:0] in  - index granted most recently
//               idx   [W-1:0] out - selected index (0 when valid is low)
//               valid         out - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module mgmt_arbiter_rr_pick
    import mgmt_arbiter_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        int pos;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        // Offsets 1..N: offset N revisits 'last' itself, so a lone
        // requester that was just served can still be granted again.
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            if (!valid && req[pos]) begin
                idx   = W'(pos);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mgmt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mgmt_arbiter
// Description : Round-robin arbiter sharing one management bus between N
//               masters. Serialises transactions, inserts a two-cycle idle
//               gap after each one and turns a missing slave response into
//               a one-cycle fault pulse after TMO+1 request cycles.
// Ports       : clk, rst (async, active-high)
//               up_req/up_adr/up_rwn/up_wen/up_txd  in  - packed per-master
//               up_ack/up_err/up_rxe                out - per-master pulses
//               up_rxd                              out - shared read data
//               dn_req/dn_adr/dn_rwn/dn_wen/dn_txd  out - registered request
//               dn_ack/dn_rxe/dn_rxd                in  - slave response
//               gnt                                 out - current/last grant
//               busy                                out - not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mgmt_arbiter
    import mgmt_arbiter_pkg::*;
#(
    parameter  int N   = 4,
    parameter  int TMO = DEF_TMO,
    localparam int GW  = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          up_req,
    input  logic [ADDR_W*N-1:0]   up_adr,
    input  logic [N-1:0]          up_rwn,
    input  logic [WEN_W*N-1:0]    up_wen,
    input  logic [DATA_W*N-1:0]   up_txd,
    output logic [N-1:0]          up_ack,
    output logic [N-1:0]          up_err,
    output logic [N-1:0]          up_rxe,
    output logic [DATA_W-1:0]     up_rxd,
    output logic                  dn_req,
    output logic [ADDR_W-1:0]     dn_adr,
    output logic                  dn_rwn,
    output logic [WEN_W-1:0]      dn_wen,
    output logic [DATA_W-1:0]     dn_txd,
    input  logic                  dn_ack,
    input  logic                  dn_rxe,
    input  logic [DATA_W-1:0]     dn_rxd,
    output logic [GW-1:0]         gnt,
    output logic                  busy
);

    localparam int            CW      = $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_CNT = CW'(TMO);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] last;
    logic          gap_cnt;

    logic [GW-1:0] pick_idx;
    logic          pick_valid;

    logic          in_bus;
    logic          ack_ev;
    logic          err_ev;
    logic          rxe_ev;
    logic [N-1:0]  gnt_oh;

    mgmt_arbiter_rr_pick #(.N(N)) u_pick (
        .req   (up_req),
        .last  (last),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Upstream responses are combinational so the master sees its pulse in
    // the same cycle the slave answers; ack takes precedence over timeout.
    assign in_bus = (state == ST_BUS);
    assign ack_ev = in_bus && dn_ack;
    assign err_ev = in_bus && !dn_ack && (cnt == TMO_CNT);
    assign rxe_ev = ack_ev && dn_rxe;
    assign gnt_oh = N'(1) << gnt;

    assign up_ack = ack_ev ? gnt_oh : '0;
    assign up_err = err_ev ? gnt_oh : '0;
    assign up_rxe = rxe_ev ? gnt_oh : '0;
    assign up_rxd = rxe_ev ? dn_rxd : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            dn_req  <= 1'b0;
            dn_adr  <= '0;
            dn_rwn  <= 1'b1;
            dn_wen  <= '0;
            dn_txd  <= '0;
            gnt     <= '0;
            last    <= GW'(N - 1);   // requester 0 wins first after reset
            cnt     <= '0;
            gap_cnt <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        dn_adr <= up_adr[pick_idx*ADDR_W +: ADDR_W];
                        dn_rwn <= up_rwn[pick_idx];
                        dn_wen <= up_wen[pick_idx*WEN_W +: WEN_W];
                        dn_txd <= up_txd[pick_idx*DATA_W +: DATA_W];
                        gnt    <= pick_idx;
                        cnt    <= '0;
                        dn_req <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (dn_ack || (cnt == TMO_CNT)) begin
                        dn_req  <= 1'b0;
                        last    <= gnt;
                        gap_cnt <= 1'b0;
                        state   <= ST_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    // Two idle cycles on the bus before arbitrating again.
                    if (gap_cnt) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                default: begin
                    dn_req <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mgmt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mgmt_arbiter
// Description : Self-checking bench for mgmt_arbiter. Directed transactions
//               push expected responses into a scoreboard queue; a monitor
//               pops and compares whenever an up_ack/up_err pulse appears,
//               and also checks request duration, idle gap and re-grant delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mgmt_arbiter;
    import mgmt_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 15;

    logic              clk;
    logic              rst;
    logic [N-1:0]      up_req;
    logic [32*N-1:0]   up_adr;
    logic [N-1:0]      up_rwn;
    logic [2*N-1:0]    up_wen;
    logic [32*N-1:0]   up_txd;
    logic [N-1:0]      up_ack;
    logic [N-1:0]      up_err;
    logic [N-1:0]      up_rxe;
    logic [31:0]       up_rxd;
    logic              dn_req;
    logic [31:0]       dn_adr;
    logic              dn_rwn;
    logic [1:0]        dn_wen;
    logic [31:0]       dn_txd;
    logic              dn_ack;
    logic              dn_rxe;
    logic [31:0]       dn_rxd;
    logic [1:0]        gnt;
    logic              busy;

    mgmt_arbiter #(.N(N), .TMO(TMO)) dut (
        .clk    (clk),
        .rst    (rst),
        .up_req (up_req),
        .up_adr (up_adr),
        .up_rwn (up_rwn),
        .up_wen (up_wen),
        .up_txd (up_txd),
        .up_ack (up_ack),
        .up_err (up_err),
        .up_rxe (up_rxe),
        .up_rxd (up_rxd),
        .dn_req (dn_req),
        .dn_adr (dn_adr),
        .dn_rwn (dn_rwn),
        .dn_wen (dn_wen),
        .dn_txd (dn_txd),
        .dn_ack (dn_ack),
        .dn_rxe (dn_rxe),
        .dn_rxd (dn_rxd),
        .gnt    (gnt),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        ack;
        logic        rxe;
        logic [31:0] rxd;
        logic [31:0] adr;
        logic        rwn;
        logic [1:0]  wen;
        logic [31:0] txd;
        int          cycles;    // expected number of dn_req-high cycles
        int          gap_exp;   // expected cycles response->next dn_req rise (0 = skip)
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // ---------------- slave model ----------------
    int          slv_lat  = 1;
    bit          slv_mute = 1'b0;
    bit          slv_fix  = 1'b0;
    logic [31:0] slv_rxd  = 32'h0;

    initial begin : slave
        int bc;
        bc     = 0;
        dn_ack = 1'b0;
        dn_rxe = 1'b0;
        dn_rxd = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            dn_ack = 1'b0;
            dn_rxe = 1'b0;
            dn_rxd = 32'h0;
            if (dn_req) begin
                if (!slv_mute && bc == slv_lat) begin
                    dn_ack = 1'b1;
                    dn_rxe = dn_rwn;
                    if (dn_rwn)
                        dn_rxd = slv_fix ? slv_rxd : (dn_adr ^ 32'h5A5A_A5A5);
                end
                bc++;
            end else begin
                bc = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int          hi;
        int          since;
        int          gap;
        logic        prev;
        exp_t        e;
        logic [N-1:0] oh;
        hi = 0; since = 1000; gap = 0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi = 0; since = 1000; gap = 0; prev = 1'b0;
            end else begin
                since++;
                if (gap > 0) begin
                    chk("gap_dn_req_low", {63'd0, dn_req}, 64'd0);
                    gap--;
                end
                if (dn_req && !prev && exp_q.size() > 0 && exp_q[0].gap_exp != 0)
                    chk("regrant_delay", since, exp_q[0].gap_exp);
                if (dn_req) hi++;
                if (|(up_ack | up_err)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", {up_ack, up_err}, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = N'(1) << e.idx;
                        chk("resp_ack_err_rxe", {up_ack, up_err, up_rxe},
                            {(e.ack ? oh : 4'b0), (e.ack ? 4'b0 : oh),
                             (e.rxe ? oh : 4'b0)});
                        chk("up_rxd", up_rxd, e.rxd);
                        chk("gnt", gnt, e.idx);
                        chk("dn_req_cycles", hi, e.cycles);
                        chk("dn_adr", dn_adr, e.adr);
                        chk("dn_rwn_wen_txd", {dn_rwn, dn_wen, dn_txd},
                            {e.rwn, e.wen, e.txd});
                    end
                    hi = 0; gap = 3; since = 0;
                end
                prev = dn_req;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int idx, input logic [31:0] adr, input logic rwn,
                         input logic [1:0] wen, input logic [31:0] txd,
                         input bit push, input logic ack, input logic [31:0] rxd,
                         input int cycles, input int gap_exp);
        exp_t e;
        up_adr[idx*32 +: 32] = adr;
        up_rwn[idx]          = rwn;
        up_wen[idx*2 +: 2]   = wen;
        up_txd[idx*32 +: 32] = txd;
        up_req[idx]          = 1'b1;
        if (push) begin
            e.idx = idx; e.ack = ack; e.rxe = ack & rwn;
            e.rxd = (ack & rwn) ? rxd : 32'h0;
            e.adr = adr; e.rwn = rwn; e.wen = wen; e.txd = txd;
            e.cycles = cycles; e.gap_exp = gap_exp;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_resp(output int who);
        who = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (|(up_ack | up_err)) begin
                for (int i = 0; i < N; i++)
                    if (up_ack[i] | up_err[i]) who = i;
                break;
            end
        end
        if (who < 0) chk("resp_wait_timeout", 64'd0, 64'd1);
        else         up_req[who] = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int w;
        rst = 1'b1; up_req = '0; up_adr = '0; up_rwn = '0; up_wen = '0; up_txd = '0;
        repeat (2) @(negedge clk);
        chk("rst_dn_req", {63'd0, dn_req}, 64'd0);
        chk("rst_dn_adr_txd", {dn_adr, dn_txd}, 64'd0);
        chk("rst_rwn_wen_gnt_busy", {dn_rwn, dn_wen, gnt, busy}, {1'b1, 2'b00, 2'b00, 1'b0});
        chk("rst_up_outputs", {up_ack, up_err, up_rxe, up_rxd}, 64'd0);
        rst = 1'b0;

        // Fairness: all four held, slave acks in the first bus cycle.
        @(posedge clk); #1;
        slv_lat = 0; slv_fix = 1'b0; slv_mute = 1'b0;
        for (int i = 0; i < N; i++)
            issue(i, 32'h100 + 32'(4*i), 1'b1, 2'b11, 32'h0, 1'b1, 1'b1,
                  (32'h100 + 32'(4*i)) ^ 32'h5A5A_A5A5, 1, (i == 0) ? 0 : 4);
        wait_resp(w);
        @(posedge clk); #1;
        issue(0, 32'h200, 1'b1, 2'b11, 32'h0, 1'b1, 1'b1, 32'h200 ^ 32'h5A5A_A5A5, 1, 4);
        repeat (4) wait_resp(w);
        repeat (4) @(negedge clk);

        // Single read, ack two cycles after dn_req rises.
        @(posedge clk); #1;
        slv_lat = 2; slv_fix = 1'b1; slv_rxd = 32'hDEAD_BEEF;
        issue(1, 32'h0000_0014, 1'b1, 2'b11, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 3, 0);
        @(negedge clk);
        chk("req_latency_before", {63'd0, dn_req}, 64'd0);
        @(negedge clk);
        chk("req_latency_after", {63'd0, dn_req}, 64'd1);
        wait_resp(w);
        repeat (4) @(negedge clk);

        // Write forwarding.
        @(posedge clk); #1;
        slv_lat = 3; slv_fix = 1'b0;
        issue(3, 32'h0000_0040, 1'b0, 2'b01, 32'h1234_5678, 1'b1, 1'b1, 32'h0, 4, 0);
        wait_resp(w);
        repeat (4) @(negedge clk);

        // Timeout: no slave answer.
        @(posedge clk); #1;
        slv_mute = 1'b1;
        issue(2, 32'hFFFF_0000, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0, TMO + 1, 0);
        wait_resp(w);
        repeat (4) @(negedge clk);

        // Ack arriving exactly when cnt == TMO.
        @(posedge clk); #1;
        slv_mute = 1'b0; slv_lat = TMO; slv_fix = 1'b1; slv_rxd = 32'hCAFE_F00D;
        issue(1, 32'h0000_0018, 1'b1, 2'b00, 32'h0, 1'b1, 1'b1, 32'hCAFE_F00D, TMO + 1, 0);
        wait_resp(w);
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of a bus transaction.
        @(posedge clk); #1;
        slv_mute = 1'b1;
        issue(2, 32'h0000_0020, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dn_req) break;
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_dn_req", {63'd0, dn_req}, 64'd0);
        chk("async_rst_busy_resp", {busy, up_ack, up_err}, 64'd0);
        up_req = '0;
        @(negedge clk);
        chk("rst_again_fields", {dn_rwn, gnt, dn_adr}, {1'b1, 2'b00, 32'h0});
        rst = 1'b0;
        @(posedge clk); #1;
        slv_mute = 1'b0; slv_lat = 1; slv_fix = 1'b0;
        issue(0, 32'h0000_0300, 1'b1, 2'b11, 32'h0, 1'b1, 1'b1, 32'h300 ^ 32'h5A5A_A5A5, 2, 0);
        issue(3, 32'h0000_0304, 1'b1, 2'b11, 32'h0, 1'b1, 1'b1, 32'h304 ^ 32'h5A5A_A5A5, 2, 4);
        repeat (2) wait_resp(w);
        repeat (5) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mgmt_arbiter.md
# mgmt_arbiter

Round-robin arbiter that shares the single management bus (req/adr/rwn/wen/txd downstream, ack/rxe/rxd upstream) between N bus masters: core load/store path, debug port, DMA. It sits between the masters and the management-bus slaves (system register file, memory controller configuration). It serialises transactions, enforces the inter-transaction idle gap the slaves require, and converts a missing slave response into a bus-fault pulse after a bounded timeout.

## Interface
- N, 4, number of upstream requesters (2..8)
- TMO, 15, cycles dn_req may stay high without dn_ack before a fault is raised (≥4)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- up_req  in  N  per-requester request, held until its up_ack/up_err
- up_adr  in  32*N  packed addresses, slice i = [32i+31:32i]
- up_rwn  in  N  1 = read, 0 = write
- up_wen  in  2*N  per-requester halfword write enables
- up_txd  in  32*N  packed write data
- up_ack  out  N  one-cycle completion pulse to the granted requester
- up_err  out  N  one-cycle timeout fault pulse to the granted requester
- up_rxe  out  N  one-cycle read-data-valid pulse to the granted requester
- up_rxd  out  32  shared read data, valid when any up_rxe bit is high, else 0
- dn_req, dn_adr[32], dn_rwn, dn_wen[2], dn_txd[32]  out  registered downstream request
- dn_ack, dn_rxe  in  1  slave completion / read valid (same cycle on reads)
- dn_rxd  in  32  slave read data, 0 when dn_rxe low
- gnt  out  clog2(N)  index of current/last granted requester
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, BUS, GAP.
- IDLE: if any up_req bit set, select the first set bit searching upward from (last+1) mod N, wrapping; last resets to N-1, so requester 0 has first priority after reset. Capture its adr/rwn/wen/txd into dn_* registers, set gnt, go BUS.
- BUS: dn_req = 1, dn_* held constant. Timeout counter cnt (width clog2(TMO+1)) starts at 0 on entry and increments each cycle.
  - dn_ack high: up_ack[gnt] = 1 combinationally that cycle; up_rxe[gnt] = dn_rxe, up_rxd = dn_rxd. Go GAP.
  - dn_ack low and cnt == TMO: up_err[gnt] = 1 that cycle; go GAP.
  - dn_ack and cnt == TMO in the same cycle: ack wins, no err.
- GAP: dn_req = 0 for exactly 2 cycles, then IDLE. up_req ignored throughout GAP.
- last updates to gnt on leaving BUS.
- No abort: a requester dropping up_req during BUS does not shorten the transaction; ack/err still pulse to it.
- dn_ack/dn_rxe outside BUS ignored; all up_ack/up_err/up_rxe 0 outside BUS.
- Write data/enables are forwarded unchanged; dn_wen is don't-care on reads but still forwarded.

## Timing
- Reset (asynchronous): state IDLE, dn_req 0, dn_adr/dn_txd 0, dn_rwn 1, dn_wen 0, gnt 0, last N-1, cnt 0, busy 0. All up_* outputs 0.
- up_req sampled at edge T in IDLE → dn_req high from T+1.
- Best case slave ack k cycles after dn_req rises → up_ack in same cycle; next grant possible at ack+3 (2 GAP cycles + 1 IDLE arbitration cycle).
- Fault: dn_req high for TMO+1 cycles (cnt 0..TMO), up_err on the last.
- Requesters must deassert up_req in the cycle after their up_ack/up_err; a request still high after GAP is treated as a new transaction.
- Reset mid-BUS: dn_req drops immediately, no ack/err delivered; requester re-issues.

## Structure
- Shared package (defines include): bus field widths (ADDR 32, DATA 32, WEN 2), default TMO, state encodings.
- One sub-module: rr_pick, combinational N-way round-robin selector (req vector, last index → grant index, valid).
- Upstream demux, rxd gating and timeout counter stay in mgmt_arbiter.

## Test plan
- Single read: req[1], adr 0x0000_0014, slave acks with rxe, rxd 0xDEAD_BEEF 2 cycles after dn_req → up_ack[1], up_rxe[1], up_rxd 0xDEAD_BEEF same cycle; dn_req low for 2 cycles after.
- Fairness: req[0..3] all held, each re-raised after ack, slave acks in 1 cycle → grant order 0,1,2,3,0; no requester granted twice before others.
- Timeout: req[2] to unmapped address, no dn_ack → dn_req high 16 cycles (TMO=15), up_err[2] on 16th, no up_ack.
- Ack at cnt == TMO → up_ack only, up_err stays 0.
- Write forwarding: req[3] wen 2'b01, txd 0x1234_5678 → dn_wen 01, dn_txd 0x1234_5678 stable until ack; up_rxe all 0.
- Reset asserted mid-BUS → dn_req 0 asynchronously, state IDLE, next request from requester 0 granted first.
